// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - 32-step restoring divider controller for DIV/DIVU; optional macro DIV_ZERO_FASTPATH_EN
module div_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready,
  output logic        stall
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
`ifdef DIV_ZERO_FASTPATH_EN
    S_DIVZERO = 2'd1,
`endif
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  localparam logic [5:0]  LAST_STEP = 6'd31;
  localparam logic [31:0] ZERO_QUO  = 32'hFFFF_FFFF;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] dvd_q, dvd_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [63:0] result_q, result_d;
`ifndef DIV_ZERO_FASTPATH_EN
  logic        zero_q, zero_d;
`endif

  logic        sign1, sign2;
  logic [31:0] mag1, mag2;
  logic [33:0] rem_sh;
  logic [32:0] rem_diff;
  logic        rem_ge;
  logic [64:0] work_step;
  logic [31:0] quo_raw, rem_raw;
  logic [31:0] quo_fix, rem_fix;
  logic [63:0] zero_result;

  // Operand magnitudes and sign flags, only meaningful on the accept edge
  always_comb begin
    sign1 = signed_div & opdata1[31];
    sign2 = signed_div & opdata2[31];
    mag1  = sign1 ? (32'd0 - opdata1) : opdata1;
    mag2  = sign2 ? (32'd0 - opdata2) : opdata2;
  end

  // One restoring step: shift partial remainder left, subtract divisor if it fits
  always_comb begin
    rem_sh    = {work_q[64:32], work_q[31]};
    rem_ge    = (rem_sh >= {2'b00, dvs_q});
    rem_diff  = rem_sh[32:0] - {1'b0, dvs_q};
    if (rem_ge) begin
      work_step = {rem_diff, work_q[30:0], 1'b1};
    end else begin
      work_step = {rem_sh[32:0], work_q[30:0], 1'b0};
    end
    quo_raw     = work_step[31:0];
    rem_raw     = work_step[63:32];
    quo_fix     = qneg_q ? (32'd0 - quo_raw) : quo_raw;
    rem_fix     = rneg_q ? (32'd0 - rem_raw) : rem_raw;
    zero_result = {dvd_q, ZERO_QUO};
  end

  // Next-state and datapath updates; annul overrides everything and leaves result alone
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    dvs_d    = dvs_q;
    dvd_d    = dvd_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
`ifndef DIV_ZERO_FASTPATH_EN
    zero_d   = zero_q;
`endif
    if (annul) begin
      state_d = S_IDLE;
      cnt_d   = 6'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_d  = 6'd0;
            work_d = {33'd0, mag1};
            dvs_d  = mag2;
            dvd_d  = opdata1;
            qneg_d = sign1 ^ sign2;
            rneg_d = sign1;
`ifdef DIV_ZERO_FASTPATH_EN
            state_d = (opdata2 == 32'd0) ? S_DIVZERO : S_ON;
`else
            zero_d  = (opdata2 == 32'd0);
            state_d = S_ON;
`endif
          end
        end
`ifdef DIV_ZERO_FASTPATH_EN
        S_DIVZERO: begin
          result_d = zero_result;
          state_d  = S_END;
        end
`endif
        S_ON: begin
          work_d = work_step;
          if (cnt_q == LAST_STEP) begin
            cnt_d = 6'd0;
`ifdef DIV_ZERO_FASTPATH_EN
            result_d = {rem_fix, quo_fix};
`else
            result_d = zero_q ? zero_result : {rem_fix, quo_fix};
`endif
            state_d = S_END;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        S_END: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      work_q   <= 65'd0;
      dvs_q    <= 32'd0;
      dvd_q    <= 32'd0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= 64'd0;
`ifndef DIV_ZERO_FASTPATH_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dvs_q    <= dvs_d;
      dvd_q    <= dvd_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
`ifndef DIV_ZERO_FASTPATH_EN
      zero_q   <= zero_d;
`endif
    end
  end

  // Outputs: ready is the END cycle unless it is being flushed; stall is purely combinational
  always_comb begin
    result = result_q;
    ready  = (state_q == S_END) & ~annul;
    stall  = start & ~ready & ~annul;
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - randomized and directed bench for div_ctrl against a transaction-level model
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] opdata1 = 32'd0;
  logic [31:0] opdata2 = 32'd0;
  logic        annul = 1'b0;
  logic [63:0] result;
  logic        ready;
  logic        stall;

  int n_pass = 0;
  int n_total = 0;

`ifdef DIV_ZERO_FASTPATH_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 32;
`endif

  div_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .stall      (stall)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] model_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Transaction model: an accepted request produces its result after a fixed number of edges
  logic        m_busy = 1'b0;
  logic        m_ready = 1'b0;
  int          m_left = 0;
  logic [63:0] m_pend = 64'd0;
  logic [63:0] m_result = 64'd0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy   <= 1'b0;
      m_ready  <= 1'b0;
      m_left   <= 0;
      m_result <= 64'd0;
    end else if (annul) begin
      m_busy  <= 1'b0;
      m_ready <= 1'b0;
    end else if (m_ready) begin
      m_ready <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy   <= 1'b0;
        m_ready  <= 1'b1;
        m_result <= m_pend;
      end
    end else if (start) begin
      m_busy <= 1'b1;
      m_pend <= model_div(signed_div, opdata1, opdata2);
      m_left <= (opdata2 == 32'd0) ? ZLAT : 32;
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    logic exp_ready, exp_stall;
    exp_ready = m_ready & ~annul;
    exp_stall = start & ~exp_ready & ~annul;
    chk("cyc_ready", {63'd0, ready}, {63'd0, exp_ready});
    chk("cyc_stall", {63'd0, stall}, {63'd0, exp_stall});
    chk("cyc_result", result, m_result);
  end

  // Entered at posedge+1 with DUT idle; returns at posedge+1 after the END cycle
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int lat);
    int  edges;
    bit  got;
    edges = 0;
    got = 0;
    start = 1'b1; signed_div = s; opdata1 = a; opdata2 = b;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      edges++;
      #1;
      opdata1 = $urandom;
      opdata2 = $urandom;
      signed_div = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (ready) got = 1;
    end
    if (!got) $display("FAIL run_div_timeout: got no ready expected ready");
    res = result;
    lat = got ? edges - 1 : -1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] res;
    int lat, edges, first, second;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", result, 64'd0);
    chk("reset_ready", {63'd0, ready}, 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    run_div(1'b0, 32'd100, 32'd7, res, lat);
    chk("divu_100_7", res, {32'd2, 32'd14});
    chk("divu_100_7_lat", 64'(lat), 64'd32);

    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, res, lat);
    chk("div_m7_2", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, res, lat);
    chk("div_7_m2", res, {32'h0000_0001, 32'hFFFF_FFFD});

    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    chk("div_min_m1", res, {32'h0, 32'h8000_0000});

    run_div(1'b0, 32'h1234, 32'd0, res, lat);
    chk("divu_zero", res, {32'h0000_1234, 32'hFFFF_FFFF});
    chk("divu_zero_lat", 64'(lat), 64'(ZLAT));

    // Annul at E10
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    repeat (10) @(posedge clk);
    #1 annul = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("annul_ready", {63'd0, ready}, 64'd0);
    chk("annul_stall", {63'd0, stall}, 64'd0);
    @(posedge clk); #1 annul = 1'b0;
    @(negedge clk);
    chk("annul_next_ready", {63'd0, ready}, 64'd0);
    chk("annul_keep_result", result, {32'h0000_1234, 32'hFFFF_FFFF});
    @(posedge clk); #1;
    run_div(1'b0, 32'd9, 32'd4, res, lat);
    chk("divu_9_4", res, {32'd1, 32'd2});
    chk("divu_9_4_lat", 64'(lat), 64'd32);

    // Async reset mid-operation at E20
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
    repeat (21) @(posedge clk);
    #3 resetn = 1'b0; start = 1'b0;
    #1;
    chk("rst_result", result, 64'd0);
    chk("rst_ready", {63'd0, ready}, 64'd0);
    @(posedge clk); #2 resetn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    run_div(1'b0, 32'd100, 32'd7, res, lat);
    chk("post_rst_div", res, {32'd2, 32'd14});
    chk("post_rst_lat", 64'(lat), 64'd32);

    // Back-to-back with start held high
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3;
    edges = 0; first = -1; second = -1;
    for (int i = 0; i < 200 && second < 0; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (ready) begin
        if (first < 0) first = edges;
        else second = edges;
      end
    end
    chk("b2b_first_lat", 64'(first - 1), 64'd32);
    chk("b2b_interval", 64'(second - first), 64'd34);
    chk("b2b_result", result, {32'd1, 32'd333});
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Randomized traffic, checked cycle by cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 3) != 0);
      signed_div = 1'($urandom_range(0, 1));
      opdata1    = pick_op();
      opdata2    = pick_op();
      annul      = ($urandom_range(0, 149) == 0);
      @(posedge clk); #1;
    end
    start = 1'b0; annul = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), in this order:
- clk  in  1  single clock; all state updates on its rising edge.
- resetn  in  1  reset, asynchronous and active-low.
- start  in  1  divide request from EX stage (DIV/DIVU decoded); held high until ready.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1  in  32  dividend (rs).
- opdata2  in  32  divisor (rt).
- annul  in  1  flush from exception/eret; aborts any operation.
- result  out  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
- ready  out  1  result valid; HI/LO write enable qualifier.
- stall  out  1  pipeline stall request.

Function
REQ-002 States SHALL be IDLE, DIVZERO, ON, END; one-hot or binary encoding is free.
REQ-003 IDLE: start=1 and annul=0 SHALL capture operands and signed_div at that edge (accept edge E0).
- Divisor nonzero -> ON.
- Divisor zero -> DIVZERO (when DIV_ZERO_FASTPATH_EN is defined).
REQ-004 On accept, signed operation SHALL latch magnitudes |opdata1| and |opdata2|, plus quotient-negate = sign1^sign2 and remainder-negate = sign1.
REQ-005 ON SHALL perform one restoring-division step per edge using a 65-bit working register and a 6-bit counter, for exactly 32 steps (edges E1..E32).
REQ-006 The edge completing step 32 SHALL load result, with the sign corrections of REQ-004 applied, and enter END.
- ready is therefore first high in the cycle after E32.
REQ-007 DIVZERO SHALL go to END on the next edge with result = {dividend as captured (unsigned bits), 32'hFFFF_FFFF}.
- ready is first high in the cycle after E1.
REQ-008 END SHALL drive ready=1 for exactly one cycle, then return to IDLE on the next edge regardless of start.
REQ-009 A new request SHALL be accepted only from IDLE; back-to-back divides therefore have one IDLE cycle between ready and the next acceptance.
REQ-010 result SHALL hold its last value from END until the next END; it is not cleared in IDLE.
REQ-011 stall SHALL be combinational: start & ~ready & ~annul.
- In END, stall=0.
- In IDLE with start=1, stall=1.
REQ-012 annul=1 in any state SHALL force next state IDLE, with priority over start and step completion.
- Counter cleared; result not updated.
- ready=0 in the annul cycle and the following cycle.
REQ-013 Signed 0x8000_0000 / 0xFFFF_FFFF SHALL yield quotient 0x8000_0000, remainder 0; no overflow flag.
REQ-014 Operand changes on opdata1/opdata2 after the accept edge SHALL have no effect on the operation in flight.

Reset
REQ-015 resetn low SHALL asynchronously force state IDLE, counter 0, working register 0, result 64'h0, ready 0.
REQ-016 Reset asserted mid-operation SHALL abort it with no result update.
- After deassertion, the first start is accepted normally.

Configuration
REQ-017 The macro DIV_ZERO_FASTPATH_EN selects divide-by-zero handling.
- Defined: zero divisor uses DIVZERO, 2-edge latency (REQ-007).
- Undefined: DIVZERO state is absent. Zero divisor runs the normal 32-step ON sequence. The END-entry edge forces result to the REQ-007 values; ready is first high after E32.
- Result values SHALL be identical in both builds.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- DIVU 100/7 -> ready first high after E32; result = {32'd2, 32'd14}; stall high E0..E32 cycles, low in END.
- DIV -7/2 -> quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF. Also DIV 7/-2 -> quotient 0xFFFF_FFFD, remainder 0x0000_0001.
- DIV 0x8000_0000/0xFFFF_FFFF -> {32'h0, 32'h8000_0000}.
- DIVU 0x1234/0:
  - with macro -> ready after E1;
  - without macro -> ready after E32;
  - both builds -> result {32'h0000_1234, 32'hFFFF_FFFF}.
- Annul at E10 of a DIVU 100/7:
  - state IDLE next cycle; ready never asserts; result keeps its prior value.
  - A following DIVU 9/4 -> {32'd1, 32'd2}.
- resetn pulsed low at E20, asynchronously between edges -> outputs zero immediately; no ready.
- Back-to-back DIVU with start held high -> second accept exactly 2 edges after first ready cycle begins.
